lc2k_regfile_sb: RTL
====================

LC2K_REGFILE_SB -- requirements
Module: lc2k_regfile_sb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports named Clk and Rst_n.
REQ-002 The block SHALL provide parameter DATA_W, default 32: register width in bits.
REQ-003 The block SHALL provide parameter NUM_REGS, default 8: number of architectural registers, range 2..64.
REQ-004 The block SHALL provide parameter ZERO_REG, default 1: if 1, register 0 is hardwired to zero.
REQ-005 The block SHALL derive ADDR_W = max(1, clog2(NUM_REGS)) and SHALL NOT expose it as a user parameter.
REQ-006 The block SHALL have these ports:
  Clk  in  1  rising-edge clock
  Rst_n  in  1  synchronous active-low reset
  rd_en  in  1  read request for both read ports
  rd_addr_a  in  ADDR_W  read port A address
  rd_addr_b  in  ADDR_W  read port B address
  rd_data_a  out  DATA_W  port A data, registered
  rd_data_b  out  DATA_W  port B data, registered
  rd_busy_a  out  1  port A register pending, registered
  rd_busy_b  out  1  port B register pending, registered
  rd_valid  out  1  rd_data and rd_busy are valid this cycle
  wr_en  in  1  write-back enable
  wr_addr  in  ADDR_W  write-back destination
  wr_data  in  DATA_W  write-back data
  rsv_en  in  1  reserve a destination (marks it pending)
  rsv_addr  in  ADDR_W  register to reserve
  err_rsv  out  1  sticky flag: double reservation seen

Function
REQ-007 All state updates SHALL occur on the rising edge of Clk; no logic SHALL use the falling edge.
REQ-008 Read latency SHALL be 1 cycle: rd_en sampled high at edge N drives rd_valid=1 and valid rd_data and rd_busy after edge N.
REQ-009 When rd_en is low at an edge, rd_valid SHALL be 0 after that edge, and rd_data and rd_busy SHALL hold their previous values.
REQ-010 A write with wr_en=1 at edge N SHALL update regs[wr_addr]=wr_data at that edge.
REQ-011 Write-first bypass: if a same-edge write targets rd_addr_x and is not discarded, rd_data_x SHALL capture wr_data.
REQ-012 With ZERO_REG=1, a write to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 with busy 0, including via bypass.
REQ-013 An address >= NUM_REGS SHALL read as data 0 and busy 0; writes and reservations to it SHALL be ignored.
REQ-014 The block SHALL keep one pending bit per register.
REQ-015 rsv_en=1 SHALL set pending[rsv_addr].
REQ-016 A write that is not discarded SHALL clear pending[wr_addr].
REQ-017 If rsv and wr target the same address at the same edge, pending SHALL end up set (the new reservation wins), and the data SHALL still be written.
REQ-018 rd_busy_x SHALL capture pending[rd_addr_x] with that edge's write-clear applied and that edge's reservation not applied, consistent with the bypass in REQ-011.
REQ-019 rsv_en to an already-pending address SHALL set err_rsv, unless a same-edge write clears that address.
REQ-020 err_rsv SHALL stay set until reset; the pending bit SHALL remain set.
REQ-021 Reserving register 0 with ZERO_REG=1 SHALL be ignored and SHALL NOT set err_rsv.
REQ-022 Ports A and B SHALL be fully independent; equal addresses SHALL return identical data and busy.

Reset
REQ-023 Rst_n low at an edge SHALL clear all registers, all pending bits, rd_data_a/b, rd_busy_a/b, rd_valid and err_rsv to 0.
REQ-024 Reset SHALL override rd_en, wr_en and rsv_en sampled at the same edge; no write or reservation SHALL take effect.
REQ-025 Reset asserted mid-operation SHALL discard all outstanding reservations; the first read after release SHALL return 0 with busy 0.

Verification
REQ-026 The bench SHALL cover write and read: wr r3=0xDEADBEEF at edge 1, then rd_en with a=3, b=3 at edge 2 -> after edge 2, rd_data_a=rd_data_b=0xDEADBEEF, rd_valid=1.
REQ-027 The bench SHALL cover bypass: at one edge wr r5=0x1234 together with rd_en a=5, b=4 -> rd_data_a=0x1234, rd_data_b=0 (r4 previously reset).
REQ-028 The bench SHALL cover the zero register: wr r0=0xFFFFFFFF, then read a=0 -> rd_data_a=0, rd_busy_a=0; rsv r0 -> err_rsv=0.
REQ-029 The bench SHALL cover the scoreboard: rsv r2, then read a=2 -> busy=1. Then wr r2=7 together with read a=2 -> data=7, busy=0. Then rsv r2 twice in a row -> err_rsv=1 and stays 1.
REQ-030 The bench SHALL cover same-edge reserve and write: rsv r6 and wr r6=9 at one edge, then read a=6 -> data=9, busy=1, err_rsv=0.
REQ-031 The bench SHALL cover reset mid-operation: r1=0xA5 with r1 pending and err_rsv=1, then Rst_n=0 for one edge together with wr r1=0x5A -> all outputs 0. A subsequent read of r1 -> data 0, busy 0.

Source files
------------

// File: rtl/lc2k_regfile_sb.sv
// LC2K register file with a per-register pending scoreboard.
// Two registered read ports, one write-back port, one reserve port.
module lc2k_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              err_rsv
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d, pend_clr;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic                busy_a_q, busy_a_d;
  logic                busy_b_q, busy_b_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                wr_ok, rsv_ok;

  // Live = in range and not the hardwired zero register.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    live = (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a
  );
    rd_val = '0;
    if (live(a)) begin
      if (wr_ok && (wr_addr == a)) rd_val = wr_data;
      else                         rd_val = regs_q[a];
    end
  endfunction

  function automatic logic rd_bsy(input logic [ADDR_W-1:0] a);
    rd_bsy = 1'b0;
    if (live(a)) rd_bsy = pend_clr[a];
  endfunction

  always_comb begin
    wr_ok    = wr_en && live(wr_addr);
    rsv_ok   = rsv_en && live(rsv_addr);
    regs_d   = regs_q;
    pend_clr = pend_q;
    if (wr_ok) begin
      regs_d[wr_addr]   = wr_data;
      pend_clr[wr_addr] = 1'b0;
    end
    pend_d = pend_clr;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    err_d = err_q | (rsv_ok && pend_clr[rsv_addr]);
    valid_d  = rd_en;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    busy_a_d = busy_a_q;
    busy_b_d = busy_b_q;
    if (rd_en) begin
      data_a_d = rd_val(rd_addr_a);
      data_b_d = rd_val(rd_addr_b);
      busy_a_d = rd_bsy(rd_addr_a);
      busy_b_d = rd_bsy(rd_addr_b);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      regs_q   <= '{default: '0};
      pend_q   <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      busy_a_q <= busy_a_d;
      busy_b_q <= busy_b_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign rd_data_a = data_a_q;
  assign rd_data_b = data_b_q;
  assign rd_busy_a = busy_a_q;
  assign rd_busy_b = busy_b_q;
  assign rd_valid  = valid_q;
  assign err_rsv   = err_q;

endmodule
